// File: rtl/mux_rr_n.sv
// mux_rr_n: round-robin NUM_CH:1 merge of valid-qualified streams with burst holding.
// Latency: one cycle from pop[i] to data_out/valid_out; switches between channels add no bubble.
// Backpressure: pause blocks every pop; the grant and the burst count hold until pause drops.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous, active-high; also forces pop to zero while high
//   data_in   - flattened channel words, channel i at [i*DATA_W +: DATA_W]
//   valid_in  - per-channel word-available flags
//   pause     - downstream stall
//   pop       - combinational one-hot (or zero) accept strobe per channel
//   data_out  - registered word accepted in the previous cycle (0 when none)
//   valid_out - registered, high when data_out carries a word
module mux_rr_n #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        valid_in,
  input  logic                     pause,
  output logic [NUM_CH-1:0]        pop,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_grant;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_last_nxt;
  logic [IDX_W-1:0]   w_grant_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_pop_vld;
  logic [IDX_W-1:0]   w_pop_idx;
  logic [NUM_CH-1:0]  w_grant_oh;
  logic [NUM_CH-1:0]  w_others;
  logic               w_limit;
  logic [IDX_W:0]     w_pick_idle;
  logic [IDX_W:0]     w_pick_sw;
  logic [DATA_W-1:0]  w_sel_dat;

  // First requesting channel scanning start, start+1, ... modulo NUM_CH.
  // Result is {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input int start, input logic [NUM_CH-1:0] req);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = IDX_W'((start + k) % NUM_CH);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_pop_vld   = 1'b0;
    w_pop_idx   = '0;
    w_grant_oh  = NUM_CH'(1) << r_grant;
    w_others    = valid_in & ~w_grant_oh;
    // The count saturates at MAX_BURST, so reaching it means the limit is hit.
    w_limit     = (MAX_BURST != 0) && (r_cnt >= CNT_MAX);
    w_pick_idle = rr_pick(int'(r_last) + 1, valid_in);
    // Switching never re-picks the current grant: it is masked out of the request set.
    w_pick_sw   = rr_pick(int'(r_grant) + 1, w_others);

    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (!pause && w_pick_idle[IDX_W]) begin
            w_pop_vld   = 1'b1;
            w_pop_idx   = w_pick_idle[IDX_W-1:0];
            w_grant_nxt = w_pick_idle[IDX_W-1:0];
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = S_BURST;
          end
        end
        S_BURST: begin
          if (!pause) begin
            // Hold the channel past the limit only when nobody else is waiting.
            if (valid_in[r_grant] && (!w_limit || (w_others == '0))) begin
              w_pop_vld = 1'b1;
              w_pop_idx = r_grant;
              if ((MAX_BURST == 0) || (r_cnt < CNT_MAX)) begin
                w_cnt_nxt = r_cnt + CNT_ONE;
              end
            end else begin
              w_last_nxt = r_grant;
              if (w_pick_sw[IDX_W]) begin
                w_pop_vld   = 1'b1;
                w_pop_idx   = w_pick_sw[IDX_W-1:0];
                w_grant_nxt = w_pick_sw[IDX_W-1:0];
                w_cnt_nxt   = CNT_ONE;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign pop       = w_pop_vld ? (NUM_CH'(1) << w_pop_idx) : '0;
  assign w_sel_dat = data_in[int'(w_pop_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_last    <= IDX_W'(NUM_CH - 1);
      r_grant   <= '0;
      r_cnt     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_cnt     <= w_cnt_nxt;
      // Idle cycles drive zero rather than holding the last word.
      data_out  <= w_pop_vld ? w_sel_dat : '0;
      valid_out <= w_pop_vld;
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: directed bench for mux_rr_n (NUM_CH=4, DATA_W=8, MAX_BURST=4).
// Latency: expected outputs trail the expected pop by one cycle.
// Backpressure: pause windows are driven directly from the vector sequence.
module tb_mux_rr_n;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [NUM_CH-1:0]        valid_in;
  logic                     pause;
  logic [NUM_CH-1:0]        pop;
  logic [DATA_W-1:0]        data_out;
  logic                     valid_out;

  int          n_checks;
  int          n_fail;
  int          cyc_no;
  logic        exp_vld;
  logic [7:0]  exp_dat;

  mux_rr_n #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .pause    (pause),
    .pop      (pop),
    .data_out (data_out),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc_no, obs, exp);
    end
  endtask

  // Channel i word in cycle c: distinct per channel and per cycle.
  function automatic logic [7:0] chan_word(input int ch, input int c);
    return 8'(ch * 64 + (c % 64));
  endfunction

  // One cycle: drive inputs, check pop and the registered outputs from the
  // previous cycle, then derive what the outputs must show next cycle.
  task automatic step(input string tag, input logic rst, input logic [3:0] vin,
                      input logic pse, input logic [3:0] exp_pop);
    logic [7:0] nxt_dat;
    reset    = rst;
    valid_in = vin;
    pause    = pse;
    for (int i = 0; i < NUM_CH; i++) begin
      data_in[i*DATA_W +: DATA_W] = chan_word(i, cyc_no);
    end
    #1;
    check_eq({tag, ".pop"}, 32'(pop), 32'(exp_pop));
    check_eq({tag, ".vout"}, 32'(valid_out), 32'(exp_vld));
    check_eq({tag, ".dout"}, 32'(data_out), 32'(exp_dat));
    check_eq({tag, ".onehot"}, 32'($onehot0(pop)), 32'd1);
    nxt_dat = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (exp_pop[i]) nxt_dat = chan_word(i, cyc_no);
    end
    exp_vld = (exp_pop != 4'b0000);
    exp_dat = nxt_dat;
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc_no   = 0;
    reset    = 1'b1;
    valid_in = 4'b1111;
    pause    = 1'b0;
    data_in  = '0;
    exp_vld  = 1'b0;
    exp_dat  = 8'h00;
    @(posedge clk);
    #1;

    // 1. Reset with all channels valid, then channel 0 first.
    step("rst_hold0", 1'b1, 4'b1111, 1'b0, 4'b0000);
    step("rst_hold1", 1'b1, 4'b1111, 1'b0, 4'b0000);
    step("rst_first", 1'b0, 4'b1111, 1'b0, 4'b0001);
    step("rst_drain", 1'b0, 4'b0000, 1'b0, 4'b0000);
    step("rst_empty", 1'b0, 4'b0000, 1'b0, 4'b0000);

    // 2. Single channel past the burst limit: no forced rotation.
    step("single_rst", 1'b1, 4'b0000, 1'b0, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      step("single", 1'b0, 4'b0100, 1'b0, 4'b0100);
    end
    step("single_end", 1'b0, 4'b0000, 1'b0, 4'b0000);
    step("single_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);

    // 3. Two channels: four words each, then back to channel 0.
    step("burst_rst", 1'b1, 4'b0000, 1'b0, 4'b0000);
    for (int k = 0; k < 4; k++) step("burst_ch0a", 1'b0, 4'b0011, 1'b0, 4'b0001);
    for (int k = 0; k < 4; k++) step("burst_ch1", 1'b0, 4'b0011, 1'b0, 4'b0010);
    for (int k = 0; k < 2; k++) step("burst_ch0b", 1'b0, 4'b0011, 1'b0, 4'b0001);
    step("burst_end", 1'b0, 4'b0000, 1'b0, 4'b0000);
    step("burst_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);

    // 4. Channel 3 drops valid mid-burst: channel 0 takes over the same cycle.
    step("hand_rst", 1'b1, 4'b0000, 1'b0, 4'b0000);
    step("hand_ch3a", 1'b0, 4'b1000, 1'b0, 4'b1000);
    step("hand_ch3b", 1'b0, 4'b1001, 1'b0, 4'b1000);
    step("hand_ch0a", 1'b0, 4'b0001, 1'b0, 4'b0001);
    step("hand_ch0b", 1'b0, 4'b0001, 1'b0, 4'b0001);
    step("hand_end", 1'b0, 4'b0000, 1'b0, 4'b0000);
    step("hand_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);

    // 5. Pause with channel 1 at cnt=2: two more words after release.
    step("pause_rst", 1'b1, 4'b0000, 1'b0, 4'b0000);
    step("pause_ch1a", 1'b0, 4'b0010, 1'b0, 4'b0010);
    step("pause_ch1b", 1'b0, 4'b0011, 1'b0, 4'b0010);
    for (int k = 0; k < 3; k++) step("pause_hold", 1'b0, 4'b0011, 1'b1, 4'b0000);
    step("pause_ch1c", 1'b0, 4'b0011, 1'b0, 4'b0010);
    step("pause_ch1d", 1'b0, 4'b0011, 1'b0, 4'b0010);
    step("pause_rot", 1'b0, 4'b0011, 1'b0, 4'b0001);
    step("pause_end", 1'b0, 4'b0000, 1'b0, 4'b0000);
    step("pause_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);

    // 6. Reset with channel 2 at cnt=3: channel 0 next, full fresh burst.
    step("mrst_rst", 1'b1, 4'b0000, 1'b0, 4'b0000);
    step("mrst_ch2a", 1'b0, 4'b0100, 1'b0, 4'b0100);
    step("mrst_ch2b", 1'b0, 4'b1111, 1'b0, 4'b0100);
    step("mrst_ch2c", 1'b0, 4'b1111, 1'b0, 4'b0100);
    step("mrst_pulse", 1'b1, 4'b1111, 1'b0, 4'b0000);
    for (int k = 0; k < 4; k++) step("mrst_ch0", 1'b0, 4'b1111, 1'b0, 4'b0001);
    step("mrst_ch1", 1'b0, 4'b1111, 1'b0, 4'b0010);
    step("mrst_end", 1'b0, 4'b0000, 1'b0, 4'b0000);
    step("mrst_idle", 1'b0, 4'b0000, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- N-channel, parametrised successor of the two-input valid/data mux.
- Merges NUM_CH valid-qualified input streams onto one output stream.
- Arbitration is round-robin with burst holding: the granted channel keeps the output while its valid stays high, up to a configurable burst limit.
- Sits between per-lane FIFOs (drained through per-channel pop strobes) and a single downstream consumer that can stall the block with pause.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 8, width of each data word.
- MAX_BURST, 4, maximum consecutive words from one channel while another channel is valid. 0 = unlimited burst.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  NUM_CH*DATA_W  flattened channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- valid_in  input  NUM_CH  bit i high = channel i has a word available.
- pause  input  1  downstream stall; while high, no word is accepted.
- pop  output  NUM_CH  combinational, one-hot or zero; bit i high = channel i's word is accepted this cycle.
- data_out  output  DATA_W  registered output word.
- valid_out  output  1  registered; high = data_out holds a word accepted the previous cycle.

Behaviour:
- Reset (reset high at a clk edge), regardless of state or mid-burst:
  - state = IDLE; last = NUM_CH-1, so channel 0 has first priority; grant = 0; cnt = 0.
  - data_out = 0, valid_out = 0.
  - pop = 0 during every cycle in which reset is high.
- Latency: a word accepted (pop[i]=1) in cycle t appears on data_out with valid_out=1 in cycle t+1.
- Output when nothing is accepted: valid_out=0 next cycle and data_out=0, never stale data.
- rr_pick(start): first channel j with valid_in[j]=1, scanning start, start+1, … mod NUM_CH. Yields none if valid_in=0.
- IDLE state:
  - If pause=1, or no valid_in is high: stay in IDLE, pop=0.
  - Otherwise: g = rr_pick(last+1); pop[g]=1; grant<=g; cnt<=1; go to BURST.
- BURST state (current grant g):
  - pause=1: pop=0; grant and cnt hold; stay in BURST.
  - Continue condition: valid_in[g]=1, AND (MAX_BURST=0, OR cnt<MAX_BURST, OR no other channel valid). Action: pop[g]=1; cnt<=min(cnt+1, MAX_BURST), where the saturation applies only when MAX_BURST≠0.
  - Switch condition: valid_in[g]=0, or the burst limit is reached while another channel is valid. Action: h = rr_pick(g+1) over channels other than g.
    - If h exists: pop[h]=1; grant<=h; cnt<=1; last<=g. Zero-bubble switch: no idle output cycle.
    - If no h exists: pop=0; last<=g; go to IDLE.
- Fairness: after a burst limit, every other valid channel is served before g is served again.
- Input rules:
  - valid_in may change freely between cycles.
  - pop is the only acceptance indication; data_in of a channel is sampled only in a cycle where its pop bit is high.
- Width rule: cnt width = clog2(MAX_BURST+1), minimum 1 bit.
- Invariant: at most one pop bit is high in any cycle.

Test Plan:
(NUM_CH=4, DATA_W=8, MAX_BURST=4 unless noted.)
1. Reset: assert reset for 2 cycles with valid_in=4'b1111 → pop=0 and valid_out=0 throughout. First cycle after release: pop=4'b0001; next cycle data_out=data_in[7:0], valid_out=1.
2. Single channel: valid_in=4'b0100 held for 6 cycles with data 0x10..0x15 → pop[2] high for all 6 cycles, no forced rotation. data_out = 0x10..0x15 one cycle later.
3. Burst limit: valid_in=4'b0011 held → channel 0 popped 4 cycles, then channel 1 popped 4 cycles, then channel 0 again. No bubble cycle on valid_out at the switch points.
4. Zero-bubble handover: channel 3 in burst, valid_in drops from 4'b1001 to 4'b0001 → pop moves to channel 0 in the same cycle; valid_out stays continuously high.
5. Pause mid-burst: channel 1 at cnt=2, pause high for 3 cycles → pop=0 and, one cycle later, valid_out=0 for those 3 cycles. After release, channel 1 gets exactly 2 more words before rotating.
6. Reset mid-burst: channel 2 at cnt=3, reset pulsed for 1 cycle with valid_in=4'b1111 → next grant is channel 0 (last reset to 3), and its cnt restarts at 1.
